masked_share_encoder: RTL and testbench

- Front end of the masked S-box datapath: takes unmasked bytes plus fresh randomness and produces a three-share Boolean encoding (sh1^sh2^sh3 = data).
- Its three share buses feed the in1/in2/in3 inputs of the two-S-box masked layer.
- Two-stage registered pipeline with valid/ready handshakes on every side; the recombination-sensitive XOR is split across register boundaries.

---
 rtl/masked_share_encoder_if.sv | 27 ++
 rtl/masked_share_encoder.sv | 142 ++++++++++++++
 tb/tb_masked_share_encoder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/masked_share_encoder_if.sv
// Share-encoder handshake bundle: plain data in, PRNG word in, three shares out.
// slave is the encoder's view, master is the driver/consumer view.
interface masked_share_encoder_if #(
  parameter int DATA_W = 8
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_W-1:0]     in_data_i;
  logic                  rnd_valid_i;
  logic                  rnd_ready_o;
  logic [2*DATA_W-1:0]   rnd_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_W-1:0]     sh1_o;
  logic [DATA_W-1:0]     sh2_o;
  logic [DATA_W-1:0]     sh3_o;

  modport slave (
    input  in_valid_i, in_data_i, rnd_valid_i, rnd_i, out_ready_i,
    output in_ready_o, rnd_ready_o, out_valid_o, sh1_o, sh2_o, sh3_o
  );

  modport master (
    output in_valid_i, in_data_i, rnd_valid_i, rnd_i, out_ready_i,
    input  in_ready_o, rnd_ready_o, out_valid_o, sh1_o, sh2_o, sh3_o
  );
endinterface

// File: rtl/masked_share_encoder.sv
// Two-stage three-share Boolean masking encoder (sh1^sh2^sh3 = data).
// Optional stuck-PRNG alarm enabled by defining ZERO_RND_DETECT_EN.
module masked_share_encoder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_i,
  masked_share_encoder_if.slave  bus,
  output logic [CNT_W-1:0]       byte_cnt_o,
  output logic                   rnd_alarm_o
);

  logic [DATA_W-1:0] r0_s;
  logic [DATA_W-1:0] r1_s;
  logic              s2_free_s;
  logic              s1_free_s;
  logic              accept_s;

  logic              v1_q,   v1_d;
  logic              v2_q,   v2_d;
  logic [DATA_W-1:0] t1_q,   t1_d;
  logic [DATA_W-1:0] m0_q,   m0_d;
  logic [DATA_W-1:0] m1_q,   m1_d;
  logic [DATA_W-1:0] sh1_q,  sh1_d;
  logic [DATA_W-1:0] sh2_q,  sh2_d;
  logic [DATA_W-1:0] sh3_q,  sh3_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  assign r0_s = bus.rnd_i[DATA_W-1:0];
  assign r1_s = bus.rnd_i[2*DATA_W-1:DATA_W];

  // Ready depends only on the partner's valid and pipeline occupancy, never on own valid.
  assign s2_free_s = !v2_q || bus.out_ready_i;
  assign s1_free_s = !v1_q || s2_free_s;
  assign accept_s  = bus.in_valid_i && bus.rnd_valid_i && s1_free_s;

  assign bus.in_ready_o  = bus.rnd_valid_i && s1_free_s;
  assign bus.rnd_ready_o = bus.in_valid_i  && s1_free_s;
  assign bus.out_valid_o = v2_q;
  assign bus.sh1_o       = sh1_q;
  assign bus.sh2_o       = sh2_q;
  assign bus.sh3_o       = sh3_q;
  assign byte_cnt_o      = cnt_q;

  // Stage 1 only folds in r0; r1 is applied after the register so data never meets both masks at once.
  always_comb begin
    v1_d = v1_q;
    t1_d = t1_q;
    m0_d = m0_q;
    m1_d = m1_q;
    if (accept_s) begin
      v1_d = 1'b1;
      t1_d = bus.in_data_i ^ r0_s;
      m0_d = r0_s;
      m1_d = r1_s;
    end else if (s1_free_s) begin
      v1_d = 1'b0;
    end else begin
      v1_d = v1_q;
    end
  end

  always_comb begin
    v2_d  = v2_q;
    sh1_d = sh1_q;
    sh2_d = sh2_q;
    sh3_d = sh3_q;
    if (s2_free_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        sh1_d = t1_q ^ m1_q;
        sh2_d = m0_q;
        sh3_d = m1_q;
      end else begin
        sh1_d = sh1_q;
      end
    end else begin
      v2_d = v2_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      t1_q  <= {DATA_W{1'b0}};
      m0_q  <= {DATA_W{1'b0}};
      m1_q  <= {DATA_W{1'b0}};
      sh1_q <= {DATA_W{1'b0}};
      sh2_q <= {DATA_W{1'b0}};
      sh3_q <= {DATA_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      t1_q  <= t1_d;
      m0_q  <= m0_d;
      m1_q  <= m1_d;
      sh1_q <= sh1_d;
      sh2_q <= sh2_d;
      sh3_q <= sh3_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef ZERO_RND_DETECT_EN
  logic alarm_q, alarm_d;

  // An all-zero mask word on an accepted byte means the PRNG is stuck; latch until reset.
  always_comb begin
    alarm_d = alarm_q;
    if (accept_s && (bus.rnd_i == {(2*DATA_W){1'b0}})) begin
      alarm_d = 1'b1;
    end else begin
      alarm_d = alarm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign rnd_alarm_o = alarm_q;
`else
  assign rnd_alarm_o = 1'b0;
`endif

endmodule

// File: tb/tb_masked_share_encoder.sv
// Randomized self-checking bench for masked_share_encoder against a queue-based
// reference: a 2-deep FIFO whose head becomes visible one edge after acceptance.
module tb_masked_share_encoder;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
`ifdef ZERO_RND_DETECT_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0]  d;
    logic [15:0] r;
    int          stamp;
  } item_t;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic [CNT_W-1:0] byte_cnt_o;
  logic rnd_alarm_o;

  masked_share_encoder_if #(.DATA_W(DATA_W)) bus ();

  masked_share_encoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .bus        (bus),
    .byte_cnt_o (byte_cnt_o),
    .rnd_alarm_o(rnd_alarm_o)
  );

  always #5 clk = ~clk;

  item_t       mq[$];
  int          cyc = 0;
  logic [15:0] m_cnt = 16'd0;
  logic        m_alarm = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  // Reference: room exists unless two bytes are held and nobody is draining.
  function automatic bit m_free();
    return (mq.size() < 2) || (bus.out_ready_i === 1'b1);
  endfunction

  function automatic bit m_valid();
    return (mq.size() > 0) && (mq[0].stamp < cyc);
  endfunction

  function automatic logic [7:0] m_plain();
    return mq[0].d;
  endfunction

  task automatic advance();
    bit acc, pop;
    acc = rst_i && bus.in_valid_i && bus.rnd_valid_i && m_free();
    pop = rst_i && m_valid() && bus.out_ready_i;
    @(posedge clk);
    cyc++;
    if (!rst_i) begin
      mq.delete();
      m_cnt = 16'd0;
      m_alarm = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{d: bus.in_data_i, r: bus.rnd_i, stamp: cyc});
        m_cnt = m_cnt + 16'd1;
        if (ALARM_EN && bus.rnd_i == 16'h0000) m_alarm = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid_i = 1'b0; bus.rnd_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    while (mq.size() > 0 && n < 10) begin
      #1;
      vectors++;
      if (bus.out_valid_o !== m_valid()) begin
        miscompares++; $display("FAIL drain_valid: got %b expected %b", bus.out_valid_o, m_valid());
      end else if (m_valid() && ((bus.sh1_o ^ bus.sh2_o ^ bus.sh3_o) !== m_plain())) begin
        miscompares++; $display("FAIL drain_data: got %h expected %h", bus.sh1_o ^ bus.sh2_o ^ bus.sh3_o, m_plain());
      end
      advance();
      n++;
    end
    if (mq.size() > 0) begin
      miscompares++; $display("FAIL drain_timeout: %0d entries left, expected 0", mq.size());
      mq.delete();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    bus.in_valid_i = 1'b1; bus.rnd_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    bus.in_data_i = 8'h5C; bus.rnd_i = 16'h1234;
    advance(); advance();
    #1;
    vectors++;
    if (bus.out_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid_o); end
    vectors++;
    if (byte_cnt_o !== 16'd0) begin miscompares++; $display("FAIL rst_cnt: got %0d expected 0", byte_cnt_o); end
    vectors++;
    if ({bus.sh1_o, bus.sh2_o, bus.sh3_o} !== 24'h0) begin
      miscompares++; $display("FAIL rst_shares: got %h expected 000000", {bus.sh1_o, bus.sh2_o, bus.sh3_o});
    end
    vectors++;
    if (rnd_alarm_o !== 1'b0) begin miscompares++; $display("FAIL rst_alarm: got %b expected 0", rnd_alarm_o); end
    rst_i = 1'b1;
    advance();
    vectors++;
    if (byte_cnt_o !== 16'd1) begin miscompares++; $display("FAIL rst_first_accept: got %0d expected 1", byte_cnt_o); end
    drain();
  endtask

  task automatic test_single();
    logic [15:0] c0;
    c0 = m_cnt;
    bus.in_valid_i = 1'b1; bus.rnd_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    bus.in_data_i = 8'hA5; bus.rnd_i = 16'h3C5A;
    advance();
    bus.in_valid_i = 1'b0; bus.rnd_valid_i = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_latency: got %b expected 0", bus.out_valid_o); end
    advance();
    #1;
    vectors++;
    if ({bus.out_valid_o, bus.sh1_o, bus.sh2_o, bus.sh3_o} !== {1'b1, 8'hC3, 8'h5A, 8'h3C}) begin
      miscompares++;
      $display("FAIL single_shares: got v=%b %h %h %h expected v=1 c3 5a 3c", bus.out_valid_o, bus.sh1_o, bus.sh2_o, bus.sh3_o);
    end
    vectors++;
    if (byte_cnt_o !== c0 + 16'd1) begin miscompares++; $display("FAIL single_cnt: got %0d expected %0d", byte_cnt_o, c0 + 16'd1); end
    drain();
  endtask

  task automatic test_stream();
    logic [15:0] c0;
    c0 = m_cnt;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.in_valid_i = 1'b1; bus.rnd_valid_i = 1'b1;
      bus.in_data_i = 8'($urandom); bus.rnd_i = 16'($urandom);
      #1;
      vectors++;
      if (bus.in_ready_o !== 1'b1 || bus.rnd_ready_o !== 1'b1) begin
        miscompares++; $display("FAIL stream_ready[%0d]: got %b%b expected 11", i, bus.in_ready_o, bus.rnd_ready_o);
      end
      if (i >= 2) begin
        vectors++;
        if (bus.out_valid_o !== 1'b1 || !m_valid()) begin
          miscompares++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, bus.out_valid_o);
        end else if ({bus.sh1_o ^ bus.sh2_o ^ bus.sh3_o, bus.sh2_o, bus.sh3_o} !== {mq[0].d, mq[0].r[7:0], mq[0].r[15:8]}) begin
          miscompares++; $display("FAIL stream_data[%0d]: got %h/%h/%h expected %h/%h/%h", i,
            bus.sh1_o ^ bus.sh2_o ^ bus.sh3_o, bus.sh2_o, bus.sh3_o, mq[0].d, mq[0].r[7:0], mq[0].r[15:8]);
        end
      end
      advance();
    end
    drain();
    vectors++;
    if (byte_cnt_o !== c0 + 16'd256) begin miscompares++; $display("FAIL stream_cnt: got %0d expected %0d", byte_cnt_o, c0 + 16'd256); end
    vectors++;
    if (rnd_alarm_o !== m_alarm) begin miscompares++; $display("FAIL stream_alarm: got %b expected %b", rnd_alarm_o, m_alarm); end
  endtask

  task automatic test_backpressure();
    logic [15:0] c0;
    logic [23:0] held;
    bit have_held = 1'b0;
    c0 = m_cnt;
    bus.out_ready_i = 1'b0; bus.in_valid_i = 1'b1; bus.rnd_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data_i = 8'($urandom); bus.rnd_i = 16'($urandom) | 16'h0100;
      #1;
      vectors++;
      if (bus.in_ready_o !== m_free() || bus.rnd_ready_o !== m_free()) begin
        miscompares++; $display("FAIL bp_ready[%0d]: got %b%b expected %b%b", i, bus.in_ready_o, bus.rnd_ready_o, m_free(), m_free());
      end
      if (have_held) begin
        vectors++;
        if ({bus.sh1_o, bus.sh2_o, bus.sh3_o} !== held || bus.out_valid_o !== 1'b1) begin
          miscompares++; $display("FAIL bp_stable[%0d]: got %h expected %h", i, {bus.sh1_o, bus.sh2_o, bus.sh3_o}, held);
        end
      end else if (bus.out_valid_o === 1'b1) begin
        held = {bus.sh1_o, bus.sh2_o, bus.sh3_o};
        have_held = 1'b1;
      end
      advance();
    end
    vectors++;
    if (byte_cnt_o !== c0 + 16'd2 || mq.size() != 2) begin
      miscompares++; $display("FAIL bp_accepts: got %0d expected 2", byte_cnt_o - c0);
    end
    drain();
  endtask

  task automatic test_handshake();
    logic [15:0] c0;
    c0 = m_cnt;
    bus.out_ready_i = 1'b1; bus.in_valid_i = 1'b1; bus.rnd_valid_i = 1'b0;
    bus.in_data_i = 8'h77; bus.rnd_i = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (bus.in_ready_o !== 1'b0 || bus.rnd_ready_o !== 1'b1 || byte_cnt_o !== c0) begin
        miscompares++; $display("FAIL hs_idle[%0d]: got in_rdy=%b rnd_rdy=%b cnt=%0d expected 0 1 %0d",
          i, bus.in_ready_o, bus.rnd_ready_o, byte_cnt_o, c0);
      end
      advance();
    end
    bus.rnd_valid_i = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready_o !== 1'b1) begin miscompares++; $display("FAIL hs_raise: got in_rdy=%b expected 1", bus.in_ready_o); end
    advance();
    vectors++;
    if (byte_cnt_o !== c0 + 16'd1) begin miscompares++; $display("FAIL hs_accept: got %0d expected %0d", byte_cnt_o, c0 + 16'd1); end
    drain();
  endtask

  task automatic test_zero_rnd();
    bus.out_ready_i = 1'b1; bus.in_valid_i = 1'b1; bus.rnd_valid_i = 1'b1;
    bus.in_data_i = 8'h11; bus.rnd_i = 16'h0000;
    advance();
    bus.in_valid_i = 1'b0; bus.rnd_valid_i = 1'b0;
    #1;
    vectors++;
    if (rnd_alarm_o !== ALARM_EN) begin miscompares++; $display("FAIL zero_alarm_set: got %b expected %b", rnd_alarm_o, ALARM_EN); end
    advance();
    #1;
    vectors++;
    if ({bus.out_valid_o, bus.sh1_o, bus.sh2_o, bus.sh3_o} !== {1'b1, 8'h11, 8'h00, 8'h00}) begin
      miscompares++; $display("FAIL zero_shares: got v=%b %h %h %h expected v=1 11 00 00", bus.out_valid_o, bus.sh1_o, bus.sh2_o, bus.sh3_o);
    end
    drain();
    bus.in_valid_i = 1'b1; bus.rnd_valid_i = 1'b1; bus.in_data_i = 8'h22; bus.rnd_i = 16'h8001;
    advance();
    drain();
    vectors++;
    if (rnd_alarm_o !== m_alarm || m_alarm !== ALARM_EN) begin
      miscompares++; $display("FAIL zero_alarm_sticky: got %b expected %b", rnd_alarm_o, ALARM_EN);
    end
    rst_i = 1'b0;
    advance();
    rst_i = 1'b1;
    #1;
    vectors++;
    if (rnd_alarm_o !== 1'b0 || byte_cnt_o !== 16'd0) begin
      miscompares++; $display("FAIL zero_alarm_reset: got alarm=%b cnt=%0d expected 0 0", rnd_alarm_o, byte_cnt_o);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid_i = 1'b0; bus.rnd_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    bus.in_data_i = 8'h00; bus.rnd_i = 16'h0000;
    @(negedge clk);
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_handshake();
    test_zero_rnd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
